mem_access: RTL and testbench

//  RV32 memory stage, directly upstream of write_back. Registers the execute result and performs
//  LB/LH/LW/LBU/LHU/SB/SH/SW on a req/ack data-memory bus. Loads are byte-lane selected and

---
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory req/ack bus between the memory stage and data memory
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  // Memory stage side: issues requests, receives completion
  modport master (
    output req, we, addr, wstrb, wdata,
    input  ack, rdata
  );

  // Data memory side
  modport slave (
    input  req, we, addr, wstrb, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32 memory stage (loads/stores on req/ack bus), optional MEM_MISALIGN_TRAP_EN
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [9:0]  opcode_info_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  input  logic        rd_write_en_i,
  input  logic [4:0]  rd_id_i,
  mem_access_if.master dmem,
  output logic        wb_valid_o,
  output logic [9:0]  opcode_info_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_read_data_o,
  output logic        rd_write_en_o,
  output logic [4:0]  rd_id_o,
  output logic        bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        load_q;
  logic        rd_we_q;
  logic [15:0] tmo_cnt;

  logic        accept;
  logic        acc_store;
  logic        acc_load;
  logic        acc_mem;
  logic        misalign;
  logic [1:0]  lane_in;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign accept  = valid_i & ready_o;
  assign lane_in = alu_result_i[1:0];

  // Decode the incoming op; store wins when both load and store bits are set
  always_comb begin
    acc_store = opcode_info_i[5];
    acc_load  = opcode_info_i[4] & ~opcode_info_i[5];
    acc_mem   = acc_store | acc_load;
    misalign  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (acc_mem) begin
      case (funct3_i[1:0])
        2'b00:   misalign = 1'b0;
        2'b01:   misalign = lane_in[0];
        default: misalign = (lane_in != 2'b00);
      endcase
    end
`endif
  end

  // Store strobes and lane-replicated write data
  always_comb begin
    st_wstrb = 4'hF;
    st_wdata = rs2_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << lane_in;
        st_wdata = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        st_wstrb = lane_in[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rs2_data_i[15:0]}};
      end
      default: begin
        st_wstrb = 4'hF;
        st_wdata = rs2_data_i;
      end
    endcase
  end

  // Load lane select and sign/zero extension; unknown sizes read the full word
  always_comb begin
    ld_byte = dmem.rdata[7:0];
    case (lane_q)
      2'd0:    ld_byte = dmem.rdata[7:0];
      2'd1:    ld_byte = dmem.rdata[15:8];
      2'd2:    ld_byte = dmem.rdata[23:16];
      default: ld_byte = dmem.rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem.rdata;
    endcase
  end

  // Stage FSM: accept, run the bus access with timeout, present one write-back pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ready_o         <= 1'b1;
      wb_valid_o      <= 1'b0;
      opcode_info_o   <= '0;
      alu_result_o    <= '0;
      mem_read_data_o <= '0;
      rd_write_en_o   <= 1'b0;
      rd_id_o         <= '0;
      bus_err_o       <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o      <= 1'b0;
`endif
      dmem.req        <= 1'b0;
      dmem.we         <= 1'b0;
      dmem.addr       <= '0;
      dmem.wstrb      <= '0;
      dmem.wdata      <= '0;
      funct3_q        <= '0;
      lane_q          <= '0;
      load_q          <= 1'b0;
      rd_we_q         <= 1'b0;
      tmo_cnt         <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      bus_err_o  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            opcode_info_o <= opcode_info_i;
            alu_result_o  <= alu_result_i;
            rd_id_o       <= rd_id_i;
            funct3_q      <= funct3_i;
            lane_q        <= lane_in;
            load_q        <= acc_load;
            rd_we_q       <= rd_write_en_i;
            tmo_cnt       <= '0;
            if (acc_mem && misalign) begin
              // Trapped access: no bus cycle, report through write-back
              state           <= DONE;
              ready_o         <= 1'b0;
              wb_valid_o      <= 1'b1;
              mem_read_data_o <= '0;
              rd_write_en_o   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
              misalign_o      <= 1'b1;
`endif
            end else if (acc_mem) begin
              state      <= BUS;
              ready_o    <= 1'b0;
              dmem.req   <= 1'b1;
              dmem.we    <= acc_store;
              dmem.addr  <= {alu_result_i[31:2], 2'b00};
              dmem.wstrb <= acc_store ? st_wstrb : 4'h0;
              dmem.wdata <= acc_store ? st_wdata : 32'h0;
            end else begin
              // Non-memory ops write back straight from IDLE so they never stall
              wb_valid_o      <= 1'b1;
              mem_read_data_o <= '0;
              rd_write_en_o   <= rd_write_en_i;
            end
          end
        end
        BUS: begin
          if (dmem.ack) begin
            dmem.req        <= 1'b0;
            dmem.we         <= 1'b0;
            dmem.wstrb      <= 4'h0;
            wb_valid_o      <= 1'b1;
            mem_read_data_o <= load_q ? ld_data : 32'h0;
            rd_write_en_o   <= rd_we_q;
            state           <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            dmem.req        <= 1'b0;
            dmem.we         <= 1'b0;
            dmem.wstrb      <= 4'h0;
            wb_valid_o      <= 1'b1;
            bus_err_o       <= 1'b1;
            mem_read_data_o <= '0;
            rd_write_en_o   <= 1'b0;
            state           <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [9:0]  opcode_info_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i;
  logic [31:0] rs2_data_i;
  logic        rd_write_en_i;
  logic [4:0]  rd_id_i;
  logic        wb_valid_o;
  logic [9:0]  opcode_info_o;
  logic [31:0] alu_result_o;
  logic [31:0] mem_read_data_o;
  logic        rd_write_en_o;
  logic [4:0]  rd_id_o;
  logic        bus_err_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int accepts;
  logic saw_ready;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .opcode_info_i   (opcode_info_i),
    .funct3_i        (funct3_i),
    .alu_result_i    (alu_result_i),
    .rs2_data_i      (rs2_data_i),
    .rd_write_en_i   (rd_write_en_i),
    .rd_id_i         (rd_id_i),
    .dmem            (bus.master),
    .wb_valid_o      (wb_valid_o),
    .opcode_info_o   (opcode_info_o),
    .alu_result_o    (alu_result_o),
    .mem_read_data_o (mem_read_data_o),
    .rd_write_en_o   (rd_write_en_o),
    .rd_id_o         (rd_id_o),
    .bus_err_o       (bus_err_o)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_o      (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [9:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    valid_i       = 1'b1;
    opcode_info_i = op;
    funct3_i      = f3;
    alu_result_i  = a;
    rs2_data_i    = d;
    rd_write_en_i = 1'b1;
    rd_id_i       = rd;
    step();
    valid_i = 1'b0;
  endtask

  // n bus cycles with req expected high; ack on the last one if do_ack
  task automatic bus_cycles(input int n, input logic do_ack, input logic [31:0] data,
                            input logic [31:0] exp_addr);
    for (int i = 1; i <= n; i++) begin
      check("req_held", bus.req, 1'b1);
      check("addr_held", bus.addr, exp_addr);
      if (i == n && do_ack) begin
        bus.ack   = 1'b1;
        bus.rdata = data;
      end
      step();
      bus.ack = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_i = 1'b0; opcode_info_i = '0; funct3_i = '0; alu_result_i = '0;
    rs2_data_i = '0; rd_write_en_i = 1'b0; rd_id_i = '0;
    bus.ack = 1'b0; bus.rdata = '0;
    step(); step();
    check("rst_ready", ready_o, 1'b1);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_req", bus.req, 1'b0);
    check("rst_bus_err", bus_err_o, 1'b0);
    check("rst_rd_we", rd_write_en_o, 1'b0);
    rst = 1'b0;
    step();

    // ADD
    issue(10'h001, 3'b000, 32'h1234, 32'h0, 5'd5);
    check("add_wb_valid", wb_valid_o, 1'b1);
    check("add_alu", alu_result_o, 32'h1234);
    check("add_rd_we", rd_write_en_o, 1'b1);
    check("add_rd_id", rd_id_o, 32'd5);
    check("add_mrd", mem_read_data_o, 32'h0);
    check("add_ready", ready_o, 1'b1);
    step();
    check("add_wb_drop", wb_valid_o, 1'b0);

    // LB 0x103 -> sign-extended 0x80
    issue(10'h010, 3'b000, 32'h103, 32'h0, 5'd6);
    check("lb_we", bus.we, 1'b0);
    check("lb_wstrb", bus.wstrb, 4'h0);
    check("lb_ready", ready_o, 1'b0);
    bus_cycles(3, 1'b1, 32'h80FF_0000, 32'h100);
    check("lb_wb_valid", wb_valid_o, 1'b1);
    check("lb_data", mem_read_data_o, 32'hFFFF_FF80);
    check("lb_req_drop", bus.req, 1'b0);
    check("lb_rd_we", rd_write_en_o, 1'b1);
    step();
    check("lb_ready_back", ready_o, 1'b1);

    // LBU 0x103 -> zero-extended
    issue(10'h010, 3'b100, 32'h103, 32'h0, 5'd6);
    bus_cycles(3, 1'b1, 32'h80FF_0000, 32'h100);
    check("lbu_data", mem_read_data_o, 32'h0000_0080);
    step();

    // LH / LHU upper half
    issue(10'h010, 3'b001, 32'h102, 32'h0, 5'd7);
    bus_cycles(1, 1'b1, 32'h8001_7FFF, 32'h100);
    check("lh_data", mem_read_data_o, 32'hFFFF_8001);
    step();
    issue(10'h010, 3'b101, 32'h102, 32'h0, 5'd7);
    bus_cycles(1, 1'b1, 32'h8001_7FFF, 32'h100);
    check("lhu_data", mem_read_data_o, 32'h0000_8001);
    step();

    // SH 0x202
    issue(10'h020, 3'b001, 32'h202, 32'h0000_ABCD, 5'd0);
    check("sh_we", bus.we, 1'b1);
    check("sh_wstrb", bus.wstrb, 4'b1100);
    check("sh_wdata", bus.wdata, 32'hABCD_ABCD);
    bus_cycles(1, 1'b1, 32'hFFFF_FFFF, 32'h200);
    check("sh_wb_valid", wb_valid_o, 1'b1);
    check("sh_mrd", mem_read_data_o, 32'h0);
    step();

    // SB 0x101, load+store bits both set -> store
    issue(10'h030, 3'b000, 32'h101, 32'h1234_5678, 5'd0);
    check("sb_we", bus.we, 1'b1);
    check("sb_wstrb", bus.wstrb, 4'b0010);
    check("sb_wdata", bus.wdata, 32'h7878_7878);
    bus_cycles(1, 1'b1, 32'h0, 32'h100);
    step();

    // SW
    issue(10'h020, 3'b010, 32'h300, 32'hCAFE_F00D, 5'd0);
    check("sw_wstrb", bus.wstrb, 4'hF);
    check("sw_wdata", bus.wdata, 32'hCAFE_F00D);
    bus_cycles(2, 1'b1, 32'h0, 32'h300);
    step();

`ifndef MEM_MISALIGN_TRAP_EN
    // LW with low address bits set: ignored, word access proceeds
    issue(10'h010, 3'b010, 32'h3, 32'h0, 5'd8);
    bus_cycles(1, 1'b1, 32'hDEAD_BEEF, 32'h0);
    check("lw_unal_data", mem_read_data_o, 32'hDEAD_BEEF);
    step();
`else
    issue(10'h010, 3'b010, 32'h2, 32'h0, 5'd8);
    check("mis_req", bus.req, 1'b0);
    check("mis_flag", misalign_o, 1'b1);
    check("mis_wb_valid", wb_valid_o, 1'b1);
    check("mis_rd_we", rd_write_en_o, 1'b0);
    step();
`endif

    // Timeout, then back-to-back ADD
    issue(10'h010, 3'b010, 32'h40, 32'h0, 5'd9);
    bus_cycles(TMO, 1'b0, 32'h0, 32'h40);
    check("tmo_req_drop", bus.req, 1'b0);
    check("tmo_bus_err", bus_err_o, 1'b1);
    check("tmo_wb_valid", wb_valid_o, 1'b1);
    check("tmo_rd_we", rd_write_en_o, 1'b0);
    check("tmo_mrd", mem_read_data_o, 32'h0);
    step();
    check("tmo_ready_back", ready_o, 1'b1);
    issue(10'h001, 3'b000, 32'h77, 32'h0, 5'd3);
    check("b2b_wb_valid", wb_valid_o, 1'b1);
    check("b2b_bus_err", bus_err_o, 1'b0);
    check("b2b_rd_we", rd_write_en_o, 1'b1);
    check("b2b_alu", alu_result_o, 32'h77);
    step();

    // Ack on the final allowed cycle wins over the timeout
    issue(10'h010, 3'b010, 32'h44, 32'h0, 5'd9);
    bus_cycles(TMO, 1'b1, 32'h1357_9BDF, 32'h44);
    check("lastack_bus_err", bus_err_o, 1'b0);
    check("lastack_data", mem_read_data_o, 32'h1357_9BDF);
    step();

    // valid_i held across a 5-cycle load: exactly one extra accept
    valid_i = 1'b1; opcode_info_i = 10'h010; funct3_i = 3'b010;
    alu_result_i = 32'h80; rd_write_en_i = 1'b1; rd_id_i = 5'd4;
    step();
    opcode_info_i = 10'h001; alu_result_i = 32'h55; rd_id_i = 5'd7;
    accepts = 0;
    saw_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (ready_o) saw_ready = 1'b1;
      if (ready_o && valid_i) accepts++;
      if (i == 5) begin
        bus.ack = 1'b1;
        bus.rdata = 32'h11;
      end
      step();
      bus.ack = 1'b0;
    end
    check("hold_ready_low", saw_ready, 1'b0);
    check("hold_load_data", mem_read_data_o, 32'h11);
    for (int i = 0; i < 2; i++) begin
      if (ready_o && valid_i) accepts++;
      step();
    end
    valid_i = 1'b0;
    check("hold_add_wb", wb_valid_o, 1'b1);
    check("hold_add_alu", alu_result_o, 32'h55);
    check("hold_accepts", accepts, 32'd1);
    step();

    // Spurious ack while idle
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("spur_req", bus.req, 1'b0);
    check("spur_wb_valid", wb_valid_o, 1'b0);
    check("spur_ready", ready_o, 1'b1);

    // Reset in the middle of a bus access
    issue(10'h010, 3'b010, 32'h90, 32'h0, 5'd2);
    step();
    rst = 1'b1;
    #1;
    check("mrst_req", bus.req, 1'b0);
    check("mrst_wb_valid", wb_valid_o, 1'b0);
    check("mrst_ready", ready_o, 1'b1);
    step();
    rst = 1'b0;
    step();
    check("mrst_no_wb", wb_valid_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
